axi_wr_burst_sched: RTL and testbench

//  Round-robin write-burst scheduler in front of the shared AXI slave write path.

---
 rtl/axi_arb_pkg.sv | 15 +
 rtl/axi_wr_burst_sched_if.sv | 32 +++
 rtl/axi_wr_burst_sched_rr_pick.sv | 40 ++++
 rtl/axi_wr_burst_sched.sv | 97 +++++++++
 tb/tb_axi_wr_burst_sched.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and default sizing for the AXI write-burst scheduler.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } state_e;

  localparam int unsigned NMstDef     = 6;
  localparam int unsigned MaxBeatsDef = 16;
  localparam int unsigned CntWDef     = 5;

endpackage

// File: rtl/axi_wr_burst_sched_if.sv
// Request/handshake/select bundle between the masters, the slave write path and the scheduler.
interface axi_wr_burst_sched_if
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_MST = NMstDef,
  parameter int unsigned CNT_W = CntWDef
);

  logic [N_MST-1:0] req;
  logic             s_awready;
  logic             s_wvalid;
  logic             s_wready;
  logic             s_wlast;
  logic             s_bvalid;
  logic             s_bready;
  logic [N_MST-1:0] m_sel;
  logic             busy;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_len;

  // The scheduler owns the select bus, so it takes the master side.
  modport master (
    input  req, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
    output m_sel, busy, beat_cnt, err_len
  );

  modport slave (
    output req, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready,
    input  m_sel, busy, beat_cnt, err_len
  );

endinterface

// File: rtl/axi_wr_burst_sched_rr_pick.sv
// Combinational round-robin picker: first request strictly above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int unsigned N = 6,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [PtrW-1:0] pick,
  output logic            any
);

  logic [N-1:0]  rot;
  logic [PtrW:0] start;
  logic [PtrW:0] off;
  logic [PtrW:0] sum;
  logic          found;

  always_comb begin
    start = {1'b0, ptr} + 1'b1;
    // Doubling req lets a single shift rotate the search origin to ptr+1.
    rot   = N'({req, req} >> start);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = (PtrW+1)'(i);
      end
    end
    sum = start + off;
    if (sum >= (PtrW+1)'(N)) begin
      sum = sum - (PtrW+1)'(N);
    end
    pick  = sum[PtrW-1:0];
    any   = found;
    grant = any ? (N'(1) << pick) : '0;
  end

endmodule

// File: rtl/axi_wr_burst_sched.sv
// Round-robin write-burst scheduler: grants one master for a whole AW->W->B transaction.
module axi_wr_burst_sched
  import axi_arb_pkg::*;
#(
  parameter int unsigned N_MST     = NMstDef,
  parameter int unsigned MAX_BEATS = MaxBeatsDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input logic                 clk,
  input logic                 rst,
  axi_wr_burst_sched_if.master bus
);

  localparam int unsigned PtrW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam logic [CNT_W-1:0] MaxBeats = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e           state_q;
  logic [N_MST-1:0] m_sel_q;
  logic             busy_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             err_len_q;
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW-1:0]  gnt_idx_q;

  logic [N_MST-1:0] grant;
  logic [PtrW-1:0]  pick;
  logic             any;

  rr_pick #(
    .N (N_MST)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (grant),
    .pick  (pick),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      m_sel_q    <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
      ptr_q      <= PtrW'(N_MST - 1);
      gnt_idx_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any) begin
            m_sel_q   <= grant;
            gnt_idx_q <= pick;
            busy_q    <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          // Only the granted master's AWVALID counts; grant is never withdrawn here.
          if ((|(bus.req & m_sel_q)) && bus.s_awready) begin
            beat_cnt_q <= '0;
            state_q    <= StData;
          end
        end
        StData: begin
          if (bus.s_wvalid && bus.s_wready) begin
            if (beat_cnt_q != CntMax) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (beat_cnt_q >= MaxBeats) begin
              err_len_q <= 1'b1;
            end
            if (bus.s_wlast) begin
              state_q <= StResp;
            end
          end
        end
        StResp: begin
          if (bus.s_bvalid && bus.s_bready) begin
            ptr_q   <= gnt_idx_q;
            m_sel_q <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_sel    = m_sel_q;
  assign bus.busy     = busy_q;
  assign bus.beat_cnt = beat_cnt_q;
  assign bus.err_len  = err_len_q;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Scoreboard bench for axi_wr_burst_sched: expected grants queued at request time.
module tb_axi_wr_burst_sched;

  localparam int N    = 6;
  localparam int MaxB = 16;
  localparam int CW   = 5;
  localparam int CntSat = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_wr_burst_sched_if #(.N_MST(N), .CNT_W(CW)) bus ();

  axi_wr_burst_sched #(
    .N_MST     (N),
    .MAX_BEATS (MaxB),
    .CNT_W     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_checks  = 0;
  int           n_pass    = 0;
  int           model_ptr = N - 1;
  logic         exp_err   = 1'b0;
  logic [N-1:0] exp_q[$];
  int           lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_model(input int ptr, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic clear_inputs();
    bus.req       = '0;
    bus.s_awready = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_wready  = 1'b0;
    bus.s_wlast   = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.s_bready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) tick();
    rst       = 1'b0;
    model_ptr = N - 1;
    exp_err   = 1'b0;
  endtask

  // One full transaction; abort_at > 0 asserts reset after that many beats.
  task automatic do_txn(input logic [N-1:0] r, input logic [N-1:0] r_mid, input int beats,
                        input int stall, input int abort_at, output int lat_o);
    int           pick;
    int           exp_cnt;
    logic [N-1:0] one;
    logic [N-1:0] exp_sel;
    one     = 1;
    bus.req = r;
    pick    = rr_model(model_ptr, r);
    exp_q.push_back(one << pick);
    lat_o = 0;
    while (bus.m_sel == '0 && lat_o < 20) begin
      tick();
      lat_o++;
    end
    exp_sel = exp_q.pop_front();
    check("grant", 32'(bus.m_sel), 32'(exp_sel));
    check("busy_on", 32'(bus.busy), 32'd1);
    bus.s_awready = 1'b1;
    tick();
    bus.s_awready = 1'b0;
    check("cnt_after_aw", 32'(bus.beat_cnt), 32'd0);
    bus.req      = r_mid;
    bus.s_wvalid = 1'b1;
    bus.s_wready = 1'b0;
    bus.s_wlast  = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("cnt_stall", 32'(bus.beat_cnt), 32'd0);
    end
    bus.s_wready = 1'b1;
    for (int i = 0; i < beats; i++) begin
      bus.s_wlast = (i == beats - 1);
      tick();
      if (i + 1 > MaxB) exp_err = 1'b1;
      exp_cnt = (i + 1 > CntSat) ? CntSat : i + 1;
      check("cnt_beat", 32'(bus.beat_cnt), 32'(exp_cnt));
      check("err_len", 32'(bus.err_len), 32'(exp_err));
      check("sel_hold", 32'(bus.m_sel), 32'(exp_sel));
      if (i + 1 == abort_at) begin
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        check("rst_sel", 32'(bus.m_sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt", 32'(bus.beat_cnt), 32'd0);
        check("rst_err", 32'(bus.err_len), 32'd0);
        model_ptr = N - 1;
        exp_err   = 1'b0;
        return;
      end
    end
    bus.s_wvalid = 1'b0;
    bus.s_wready = 1'b0;
    bus.s_wlast  = 1'b0;
    tick();
    check("busy_resp", 32'(bus.busy), 32'd1);
    check("sel_resp", 32'(bus.m_sel), 32'(exp_sel));
    bus.s_bvalid = 1'b1;
    bus.s_bready = 1'b1;
    tick();
    bus.s_bvalid = 1'b0;
    bus.s_bready = 1'b0;
    exp_cnt = (beats > CntSat) ? CntSat : beats;
    check("sel_off", 32'(bus.m_sel), 32'd0);
    check("busy_off", 32'(bus.busy), 32'd0);
    check("cnt_keep", 32'(bus.beat_cnt), 32'(exp_cnt));
    check("err_keep", 32'(bus.err_len), 32'(exp_err));
    model_ptr = pick;
  endtask

  initial begin
    do_reset();
    check("reset_sel", 32'(bus.m_sel), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_cnt", 32'(bus.beat_cnt), 32'd0);
    check("reset_err", 32'(bus.err_len), 32'd0);

    // Single requester, 4-beat burst
    do_txn(6'b000001, 6'b000001, 4, 0, 0, lat);
    check("t1_latency", 32'(lat), 32'd1);

    // All requesting: rotation m0..m5 then m0
    do_reset();
    for (int t = 0; t < 7; t++) do_txn(6'b111111, 6'b111111, 1, 0, 0, lat);

    // New request during DATA waits, then granted one cycle into IDLE
    do_txn(6'b000100, 6'b100000, 2, 0, 0, lat);
    do_txn(6'b100000, 6'b100000, 1, 0, 0, lat);
    check("t3_latency", 32'(lat), 32'd1);

    // Over-length burst sets sticky err_len
    do_txn(6'b000001, 6'b000001, 17, 0, 0, lat);

    // Write stall with wready low; err_len must still be held
    do_txn(6'b001000, 6'b001000, 3, 5, 0, lat);

    // Reset mid-burst at beat 2, then m1 granted normally
    do_txn(6'b000100, 6'b000100, 4, 0, 2, lat);
    do_txn(6'b000010, 6'b000010, 2, 0, 0, lat);
    check("t5_latency", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
